// File: rtl/counter_pkg.sv
// Shared constants and helpers for the binary/Gray counter family.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Full-range terminal count for the default width (2^WIDTH-1)
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_MAX = {DEFAULT_WIDTH{1'b1}};

  function automatic logic [31:0] bin2gray(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/gray_encoder.sv
// Combinational WIDTH-bit binary to Gray converter; zero latency, no flow control.
module gray_encoder
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/simple_counter.sv
// Free-running up-counter with terminal flag, registered wrap pulse and registered Gray copy.
// Count/wrap/Gray update on the same edge; tc is combinational from count; never stalls.
module simple_counter
  import counter_pkg::*;
#(
  parameter int unsigned           WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]      MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] count_gray
);

  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VALUE ^ (RESET_VALUE >> 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_gray_q, count_gray_d;
  logic             wrap_q, wrap_d;
  logic             at_max;

  assign at_max = (count_q == MAX_VALUE);

  always_comb begin
    count_d = count_q + 1'b1;
    wrap_d  = 1'b0;
    if (at_max) begin
      count_d = RESET_VALUE;
      wrap_d  = 1'b1;
    end
  end

  // Gray is taken from the next binary value so both registers move together
  gray_encoder #(.WIDTH(WIDTH)) u_gray (
    .bin  (count_d),
    .gray (count_gray_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= RESET_VALUE;
      wrap_q       <= 1'b0;
      count_gray_q <= RESET_GRAY;
    end else begin
      count_q      <= count_d;
      wrap_q       <= wrap_d;
      count_gray_q <= count_gray_d;
    end
  end

  assign count      = count_q;
  assign tc         = at_max;
  assign wrap       = wrap_q;
  assign count_gray = count_gray_q;

endmodule

// File: tb/tb_simple_counter.sv
// Bench for simple_counter: default instance plus a WIDTH=3, MAX=5, RESET=2 instance sharing rst.
module tb_simple_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [3:0] a_count, a_gray;
  logic       a_tc, a_wrap;
  logic [2:0] b_count, b_gray;
  logic       b_tc, b_wrap;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  k        = 0;   // edges since the last reset edge
  bit  have_prev = 1'b0;
  logic [3:0] prev_gray;

  always #5 clk = ~clk;

  simple_counter u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .count      (a_count),
    .tc         (a_tc),
    .wrap       (a_wrap),
    .count_gray (a_gray)
  );

  simple_counter #(
    .WIDTH       (3),
    .MAX_VALUE   (3'd5),
    .RESET_VALUE (3'd2)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .count      (b_count),
    .tc         (b_tc),
    .wrap       (b_wrap),
    .count_gray (b_gray)
  );

  // Reference: after k edges out of reset the count is R + k mod (MAX-R+1)
  function automatic int exp_count(input int r, input int m, input int kk);
    return r + (kk % (m - r + 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic step(input bit r);
    int ea, eb;
    rst = r;
    @(posedge clk);
    #1;
    if (r) k = 0;
    else   k++;
    ea = exp_count(0, 15, k);
    eb = exp_count(2, 5, k);

    check("a_count", 32'(a_count), 32'(ea));
    check("a_tc",    32'(a_tc),    32'(ea == 15));
    check("a_wrap",  32'(a_wrap),  32'(k > 0 && (k % 16) == 0));
    check("a_gray",  32'(a_gray),  32'(ea ^ (ea >> 1)));
    if (!r && have_prev)
      check("a_gray_hamming", 32'($countones(a_gray ^ prev_gray)), 32'd1);
    prev_gray = a_gray;
    have_prev = 1'b1;

    check("b_count", 32'(b_count), 32'(eb));
    check("b_tc",    32'(b_tc),    32'(eb == 5));
    check("b_wrap",  32'(b_wrap),  32'(k > 0 && (k % 4) == 0));
    check("b_gray",  32'(b_gray),  32'(eb ^ (eb >> 1)));
  endtask

  initial begin
    // Reset on the first edge, then run well past one full wrap
    step(1'b1);
    for (int i = 0; i < 24; i++) step(1'b0);

    // Reset while the default counter shows 9
    for (int i = 0; i < 16 && (k % 16) != 9; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);

    // Reset exactly at the default terminal count: wrap must stay low
    for (int i = 0; i < 16 && (k % 16) != 15; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Reset exactly at the small instance's terminal count (5)
    for (int i = 0; i < 4 && (k % 4) != 3; i++) step(1'b0);
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);

    // Held reset must not advance
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 2; i++) step(1'b0);

    // Random reset pattern
    for (int i = 0; i < 300; i++) step($urandom_range(0, 11) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
